// File: rtl/node_integrator.sv
// node_integrator: sums signed device currents into a clamped node voltage with settle detect.
// Define NODE_HYST_EN to give the digital level d threshold hysteresis.
`ifndef W
`define W 16
`endif
`ifndef HI
`define HI 8192
`endif
`ifndef LO
`define LO -8192
`endif

module node_integrator #(
  parameter int W         = `W,
  parameter int N_IN      = 4,
  parameter int CAP_SHIFT = 2,
  parameter int VHI       = `HI,
  parameter int VLO       = `LO,
  parameter int INIT      = 0,
  parameter int VTH_H     = VHI / 2,
  parameter int VTH_L     = VLO / 2,
  parameter int EPS       = 4,
  parameter int SETTLE_N  = 3
) (
  input  logic              eclk,
  input  logic              erst_n,
  input  logic [N_IN*W-1:0] i,
  input  logic              step,
  input  logic              load,
  input  logic [W-1:0]      load_v,
  output logic [W-1:0]      v,
  output logic              d,
  output logic              settled
);
  localparam int CW = W + $clog2(N_IN);
  localparam int AW = W + CAP_SHIFT + 1;
  localparam int SW = AW + CW + 1;
  localparam int QW = $clog2(SETTLE_N + 1);
  localparam logic signed [SW-1:0] AHI = SW'(VHI * (1 << CAP_SHIFT));
  localparam logic signed [SW-1:0] ALO = SW'(VLO * (1 << CAP_SHIFT));
  localparam logic signed [AW-1:0] AINIT = AW'(INIT * (1 << CAP_SHIFT));
  localparam logic signed [CW-1:0] QE = CW'(EPS);
  localparam logic [W-1:0] INIT_W = W'(INIT);
  logic signed [CW-1:0] isum;
  logic signed [SW-1:0] raw;
  logic signed [AW-1:0] acc, acc_next;
  logic signed [W-1:0] v_next;
  logic [QW-1:0] qcnt, qcnt_next;
  logic quiet, d_next;
  always_comb begin
    isum = '0;
    for (int k = 0; k < N_IN; k++) isum = isum + CW'($signed(i[k*W +: W]));
  end
  assign quiet = (isum <= QE) && (isum >= -QE);
  // Wide intermediate so the unclamped sum can never wrap before clamping
  assign raw = load ? (SW'($signed(load_v)) <<< CAP_SHIFT) : SW'(acc) + SW'(isum);
  assign acc_next = raw > AHI ? AW'(AHI) : raw < ALO ? AW'(ALO) : AW'(raw);
  assign v_next = W'(acc_next >>> CAP_SHIFT);
  assign v = W'(acc >>> CAP_SHIFT);
  assign qcnt_next = (load || !quiet) ? '0 : qcnt == QW'(SETTLE_N) ? qcnt : qcnt + 1'b1;
`ifdef NODE_HYST_EN
  localparam logic signed [W-1:0] TH_H = W'(VTH_H);
  localparam logic signed [W-1:0] TH_L = W'(VTH_L);
  localparam logic D_RST = INIT >= VTH_H;
  assign d_next = v_next >= TH_H ? 1'b1 : v_next <= TH_L ? 1'b0 : d;
`else
  localparam logic D_RST = ~INIT_W[W-1];
  assign d_next = ~v_next[W-1];
`endif
  always_ff @(posedge eclk or negedge erst_n) begin
    if (!erst_n) begin
      acc     <= AINIT;
      d       <= D_RST;
      qcnt    <= '0;
      settled <= 1'b0;
    end else if (step || load) begin
      acc     <= acc_next;
      d       <= d_next;
      qcnt    <= qcnt_next;
      settled <= qcnt_next == QW'(SETTLE_N);
    end
  end
endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: directed scoreboard bench for node_integrator (W=16, N_IN=2).
module tb_node_integrator;
`ifdef NODE_HYST_EN
  localparam logic HY = 1'b1;
`else
  localparam logic HY = 1'b0;
`endif
  localparam logic DR = ~HY;
  logic eclk = 1'b0, erst_n = 1'b0, step = 1'b0, load = 1'b0, d, settled;
  logic [31:0] i = '0;
  logic [15:0] load_v = '0, v;
  typedef struct {
    logic signed [15:0] v;
    logic d;
    logic s;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  node_integrator #(.W(16), .N_IN(2), .CAP_SHIFT(2), .VHI(8192), .VLO(-8192), .INIT(0),
    .EPS(4), .SETTLE_N(3)) dut (.eclk(eclk), .erst_n(erst_n), .i(i), .step(step), .load(load),
    .load_v(load_v), .v(v), .d(d), .settled(settled));

  always #5 eclk = ~eclk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic chk_all(input string nm, input int ev, input logic ed, input logic es);
    chk({nm, ".v"}, int'($signed(v)), ev);
    chk({nm, ".d"}, int'(d), int'(ed));
    chk({nm, ".settled"}, int'(settled), int'(es));
  endtask

  task automatic drive(input logic st, input logic ld, input int lv, input int a1, input int a0,
                       input int ev, input logic ed, input logic es);
    @(negedge eclk);
    step = st;
    load = ld;
    load_v = 16'(lv);
    i = {16'(a1), 16'(a0)};
    if (st || ld) q.push_back('{16'(ev), ed, es});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string nm);
    @(posedge eclk);
    #3 erst_n = 1'b0;
    #1 chk_all(nm, 0, DR, 1'b0);
    @(negedge eclk);
    step = 1'b0;
    load = 1'b0;
    @(negedge eclk);
    erst_n = 1'b1;
  endtask

  // Monitor: every edge that accepted a step or load must match the oldest expectation
  always @(posedge eclk) begin
    logic u;
    exp_t e;
    u = (step || load) && erst_n;
    #1;
    if (u) begin
      if (q.size() == 0) chk("unexpected_update", 1, 0);
      else begin
        e = q.pop_front();
        chk_all("sb", int'(e.v), e.d, e.s);
      end
    end
  end

  initial begin
    repeat (2) @(negedge eclk);
    erst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 0, 40, 10, DR, 1'b0);
    async_reset("reset");
    for (int k = 1; k <= 4; k++) drive(1'b1, 1'b0, 0, 0, 100, 25 * k, DR, 1'b0);
    idle(2);
    chk_all("hold", 100, DR, 1'b0);
    drive(1'b1, 1'b0, 0, 16000, 16000, 8100, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 0, 16000, 16000, 8192, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 0, 0, -4, 8191, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 4096, 0, 0, 4096, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 100, 0, 0, 100, 1'b1, 1'b0);
    drive(1'b0, 1'b1, -4096, 0, 0, -4096, 1'b0, 1'b0);
    drive(1'b0, 1'b1, -100, 0, 0, -100, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 3, -100, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 3, -99, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 3, -98, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 5, -97, 1'b0, 1'b0);
    idle(5);
    chk_all("settle_idle", -97, 1'b0, 1'b0);
    drive(1'b1, 1'b1, -20000, 0, 1000, -8192, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1000, -7942, 1'b0, 1'b0);
    async_reset("mid_reset");
    drive(1'b1, 1'b0, 0, 0, 1000, 250, DR, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1000, 500, DR, 1'b0);
    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
